// File: rtl/fifo_read_arbiter.sv
// rtl/fifo_read_arbiter.sv - round-robin read scheduler draining N FIFOs into one valid/ready stream
// Optional feature macro: ARB_BURST_EN (keep a grant for up to BURST consecutive reads).
module fifo_read_arbiter #(
   parameter int N     = 4,
   parameter int WIDTH = 64,
   parameter int BURST = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N-1:0]           q_empty,
   output logic [N-1:0]           q_ren,
   input  logic [N*WIDTH-1:0]     q_dout,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_data,
   output logic [$clog2(N)-1:0]   out_port,
   output logic                   busy
);

   localparam int PW = $clog2(N);

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    last_q, last_d;
   logic [1:0]       count_q, count_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic [WIDTH-1:0] data_q [2];
   logic [PW-1:0]    port_q [2];

   logic             inflight;
   logic             push;
   logic             pop;
   logic             credit;
   logic [2:0]       occ;
   logic             rr_found;
   logic [PW-1:0]    rr_port;
   logic [PW-1:0]    cand;
   logic             hold;
   logic             issue;
   logic [PW-1:0]    grant_port;

   // GRANT means a read was issued last cycle, so its word is on q_dout now.
   assign inflight  = (state_q == GRANT);
   assign push      = inflight;
   assign out_valid = (count_q != 2'd0);
   assign pop       = out_valid && out_ready;
   assign occ       = {1'b0, count_q} + {2'b00, inflight};
   assign credit    = (occ - {2'b00, pop}) < 3'd2;
   assign busy      = inflight || (count_q != 2'd0);
   assign out_data  = out_valid ? data_q[rd_ptr_q] : '0;
   assign out_port  = out_valid ? port_q[rd_ptr_q] : '0;

   always_comb begin
      rr_found = 1'b0;
      rr_port  = last_q;
      cand     = last_q;
      for (int k = 0; k < N; k++) begin
         cand = (cand == PW'(N - 1)) ? '0 : cand + PW'(1);
         if (!rr_found && !q_empty[cand]) begin
            rr_found = 1'b1;
            rr_port  = cand;
         end
      end
   end

`ifdef ARB_BURST_EN
   localparam int BW = $clog2(BURST + 1);
   logic [BW-1:0] bcnt_q, bcnt_d;

   // A credit stall leaves bcnt_q untouched, so the burst resumes afterwards.
   assign hold = (bcnt_q != '0) && (bcnt_q < BW'(BURST)) && !q_empty[last_q];

   always_comb begin
      bcnt_d = bcnt_q;
      if (issue) begin
         bcnt_d = hold ? bcnt_q + BW'(1) : BW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         bcnt_q <= '0;
      end else begin
         bcnt_q <= bcnt_d;
      end
   end
`else
   assign hold = 1'b0;
`endif

   always_comb begin
      grant_port = hold ? last_q : rr_port;
      issue      = reset && credit && rr_found;
      q_ren      = '0;
      q_ren[grant_port] = issue;
      state_d    = issue ? GRANT : IDLE;
      last_d     = issue ? grant_port : last_q;
   end

   always_comb begin
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (push) begin
         wr_ptr_d = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         last_q    <= PW'(N - 1);
         count_q   <= 2'd0;
         rd_ptr_q  <= 1'b0;
         wr_ptr_q  <= 1'b0;
         data_q[0] <= '0;
         data_q[1] <= '0;
         port_q[0] <= '0;
         port_q[1] <= '0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         if (push) begin
            data_q[wr_ptr_q] <= q_dout[last_q*WIDTH +: WIDTH];
            port_q[wr_ptr_q] <= last_q;
         end
      end
   end

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// tb/tb_fifo_read_arbiter.sv - directed bench for fifo_read_arbiter with behavioural FIFO bank
module tb_fifo_read_arbiter;

   localparam int N     = 4;
   localparam int WIDTH = 16;
   localparam int BURST = 2;
   localparam int DEPTH = 8;

   logic               clk = 1'b0;
   logic               reset;
   logic [N-1:0]       q_empty;
   logic [N-1:0]       q_ren;
   logic [N*WIDTH-1:0] q_dout;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   out_data;
   logic [1:0]         out_port;
   logic               busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fifo_read_arbiter #(.N(N), .WIDTH(WIDTH), .BURST(BURST)) dut (
      .clk(clk), .reset(reset), .q_empty(q_empty), .q_ren(q_ren), .q_dout(q_dout),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_port(out_port), .busy(busy)
   );

   // FIFO bank: registered dout, advanced on an accepted ren, cleared by reset
   logic [WIDTH-1:0] fmem [N][DEPTH];
   logic [WIDTH-1:0] fdout [N];
   int               wr_cnt [N];
   int               rd_cnt [N];

   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (!reset) begin
            rd_cnt[i] <= 0;
            fdout[i]  <= '0;
         end else if (q_ren[i] && rd_cnt[i] != wr_cnt[i]) begin
            fdout[i]  <= fmem[i][rd_cnt[i]];
            rd_cnt[i] <= rd_cnt[i] + 1;
         end
      end
   end

   always_comb begin
      q_empty = '0;
      q_dout  = '0;
      for (int i = 0; i < N; i++) begin
         q_empty[i] = (rd_cnt[i] == wr_cnt[i]);
         q_dout[i*WIDTH +: WIDTH] = fdout[i];
      end
   end

   int               cyc = 0;
   logic             mon_clr;
   int               ren_cnt, valid_cnt, first_ren, first_valid, viol;
   logic [N-1:0]     first_ren_vec;
   logic [WIDTH-1:0] log_data [$];
   int               log_port [$];
   int               log_cyc [$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mon_clr) begin
         ren_cnt = 0; valid_cnt = 0; first_ren = -1; first_valid = -1; viol = 0;
         first_ren_vec = '0;
         log_data.delete(); log_port.delete(); log_cyc.delete();
      end else begin
         if (q_ren != '0) begin
            ren_cnt++;
            if (first_ren < 0) begin
               first_ren = cyc;
               first_ren_vec = q_ren;
            end
         end
         if (((q_ren & q_empty) != '0) || ($countones(q_ren) > 1)) viol++;
         if (out_valid) begin
            valid_cnt++;
            if (first_valid < 0) first_valid = cyc;
         end
         if (out_valid && out_ready) begin
            log_data.push_back(out_data);
            log_port.push_back(int'(out_port));
            log_cyc.push_back(cyc);
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] log_at(input int k);
      if (k < log_data.size()) return log_data[k];
      return '1;
   endfunction

   function automatic int port_at(input int k);
      if (k < log_port.size()) return log_port[k];
      return -1;
   endfunction

   function automatic int cyc_at(input int k);
      if (k < log_cyc.size()) return log_cyc[k];
      return -1;
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic load(input int port, input int n);
      for (int j = 0; j < n; j++) fmem[port][j] = WIDTH'(port * 16 + j);
      wr_cnt[port] = n;
   endtask

   task automatic restart(input logic rdy);
      reset     = 1'b0;
      out_ready = rdy;
      mon_clr   = 1'b1;
      for (int i = 0; i < N; i++) wr_cnt[i] = 0;
      step(2);
   endtask

   task automatic release_reset();
      mon_clr = 1'b0;
      reset   = 1'b1;
   endtask

   task automatic check_seq(input string tag, input logic [WIDTH-1:0] exp[$]);
      check({tag, "_count"}, 64'(log_data.size()), 64'(exp.size()));
      for (int k = 0; k < exp.size(); k++) begin
         check($sformatf("%s_data%0d", tag, k), 64'(log_at(k)), 64'(exp[k]));
         check($sformatf("%s_port%0d", tag, k), 64'(port_at(k)), 64'(exp[k] >> 4));
      end
   endtask

   logic [WIDTH-1:0] exp_q [$];

   initial begin
      reset     = 1'b0;
      out_ready = 1'b1;
      mon_clr   = 1'b1;
      for (int i = 0; i < N; i++) begin
         wr_cnt[i] = 0;
         load(i, 2);
      end
      step(1);

      // reset held with every FIFO non-empty: all outputs quiet
      for (int r = 0; r < 3; r++) begin
         @(negedge clk);
         check("rst_q_ren", 64'(q_ren), 64'd0);
         check("rst_out_valid", 64'(out_valid), 64'd0);
         check("rst_out_data", 64'(out_data), 64'd0);
         check("rst_out_port", 64'(out_port), 64'd0);
         check("rst_busy", 64'(busy), 64'd0);
         step(1);
      end
      release_reset();
      @(negedge clk);
      check("first_ren", 64'(q_ren), 64'b0001);
      step(16);

`ifdef ARB_BURST_EN
      exp_q = '{16'h00, 16'h01, 16'h10, 16'h11, 16'h20, 16'h21, 16'h30, 16'h31};
`else
      exp_q = '{16'h00, 16'h10, 16'h20, 16'h30, 16'h01, 16'h11, 16'h21, 16'h31};
`endif
      check_seq("rr4", exp_q);
      check("rr4_latency", 64'(first_valid - first_ren), 64'd2);
      for (int k = 1; k < 8; k++)
         check($sformatf("rr4_rate%0d", k), 64'(cyc_at(k) - cyc_at(0)), 64'(k));
      check("rr4_busy_idle", 64'(busy), 64'd0);
      check("rr4_ren_total", 64'(ren_cnt), 64'd8);
      check("rr4_ren_legal", 64'(viol), 64'd0);

      // two deep ports, burst rotation
      restart(1'b1);
      load(0, 5);
      load(1, 5);
      release_reset();
      step(20);
`ifdef ARB_BURST_EN
      exp_q = '{16'h00, 16'h01, 16'h10, 16'h11, 16'h02, 16'h03, 16'h12, 16'h13, 16'h04, 16'h14};
`else
      exp_q = '{16'h00, 16'h10, 16'h01, 16'h11, 16'h02, 16'h12, 16'h03, 16'h13, 16'h04, 16'h14};
`endif
      check_seq("two", exp_q);
      check("two_ren_legal", 64'(viol), 64'd0);

      // consumer stalled: credit caps outstanding words at two
      restart(1'b0);
      load(2, 6);
      release_reset();
      step(10);
      check("stall_ren_cnt", 64'(ren_cnt), 64'd2);
      check("stall_busy", 64'(busy), 64'd1);
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_head_data", 64'(out_data), 64'h20);
      check("stall_head_port", 64'(out_port), 64'd2);
      out_ready = 1'b1;
      step(12);
      exp_q = '{16'h20, 16'h21, 16'h22, 16'h23, 16'h24, 16'h25};
      check_seq("stall", exp_q);
      check("stall_ren_total", 64'(ren_cnt), 64'd6);
      check("stall_busy_end", 64'(busy), 64'd0);
      check("stall_ren_legal", 64'(viol), 64'd0);

      // single word in port 3
      restart(1'b1);
      load(3, 1);
      release_reset();
      step(8);
      check("one_ren_cnt", 64'(ren_cnt), 64'd1);
      check("one_ren_vec", 64'(first_ren_vec), 64'b1000);
      check("one_valid_cycles", 64'(valid_cnt), 64'd1);
      check("one_latency", 64'(first_valid - first_ren), 64'd2);
      check_seq("one", '{16'h30});
      check("one_busy_end", 64'(busy), 64'd0);

      // reset right after a read is issued
      restart(1'b1);
      load(0, 3);
      load(1, 3);
      release_reset();
      @(negedge clk);
      check("mid_ren_before", 64'(q_ren), 64'b0001);
      step(1);
      reset = 1'b0;
      @(negedge clk);
      check("mid_ren_in_reset", 64'(q_ren), 64'd0);
      step(1);
      reset = 1'b1;
      @(negedge clk);
      check("mid_valid_after", 64'(out_valid), 64'd0);
      check("mid_busy_after", 64'(busy), 64'd0);
      check("mid_ren_restart", 64'(q_ren), 64'b0001);
      step(3);
      check("mid_first_data", 64'(log_at(0)), 64'h00);
      check("mid_first_port", 64'(port_at(0)), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
